// File: rtl/sng_array_if.sv
// sng_array_if -- operand/control/stream bundle of the multi-channel SNG.
//   i_x_bn          NCH packed operands, channel c at [c*WIDTH +: WIDTH]
//   i_len_msng      stream length in bits
//   i_bipolar_msng  0 = unsigned operands, 1 = two's complement operands
//   i_start_msng    start a run (honoured only while idle)
//   i_stop_msng     abort the current run
//   i_hold_msng     stall the running streams
//   o_sn_bits       one stream bit per channel
//   o_valid_msng    o_sn_bits holds a fresh stream bit
//   o_busy_msng     generator is not idle
//   o_done_msng     one-cycle pulse after a completed run
//   o_cnt_msng      bits emitted in the current or last run
// master = operand source / controller, slave = the generator.
interface sng_array_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int LEN_W = 10
);
   logic [NCH*WIDTH-1:0] i_x_bn;
   logic [LEN_W-1:0]     i_len_msng;
   logic                 i_bipolar_msng;
   logic                 i_start_msng;
   logic                 i_stop_msng;
   logic                 i_hold_msng;
   logic [NCH-1:0]       o_sn_bits;
   logic                 o_valid_msng;
   logic                 o_busy_msng;
   logic                 o_done_msng;
   logic [LEN_W-1:0]     o_cnt_msng;

   modport master (
      output i_x_bn, i_len_msng, i_bipolar_msng, i_start_msng, i_stop_msng, i_hold_msng,
      input  o_sn_bits, o_valid_msng, o_busy_msng, o_done_msng, o_cnt_msng
   );

   modport slave (
      input  i_x_bn, i_len_msng, i_bipolar_msng, i_start_msng, i_stop_msng, i_hold_msng,
      output o_sn_bits, o_valid_msng, o_busy_msng, o_done_msng, o_cnt_msng
   );
endinterface

// File: rtl/sng_array.sv
// sng_array -- NCH-channel stochastic number generator.
// Each channel compares its own maximal-length Fibonacci LFSR against a latched
// operand and emits one stream bit per non-held cycle for len cycles.
// Ports:
//   i_clk_msng  clock, rising edge
//   i_rst_msng  synchronous active-high reset
//   bus         sng_array_if.slave: operands, length, mode, start/stop/hold in;
//               stream bits, valid, busy, done, bit count out
module sng_array #(
   parameter int WIDTH     = 8,
   parameter int NCH       = 4,
   parameter int LEN_W     = 10,
   parameter int SEED_STEP = 3
) (
   input  logic        i_clk_msng,
   input  logic        i_rst_msng,
   sng_array_if.slave  bus
);

   localparam int PERIOD = (32'sd1 << WIDTH) - 32'sd1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Distinct non-zero seed per channel; the +1 keeps the LFSR out of the lock-up state.
   function automatic logic [WIDTH-1:0] seed_of(input int c);
      int s;
      s = ((c * SEED_STEP) % PERIOD) + 32'sd1;
      return s[WIDTH-1:0];
   endfunction

   // One Fibonacci step; the state is zero-padded to 8 bits so every tap index stays in range.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] r);
      logic [7:0] p;
      logic       f;
      p = 8'(r);
      case (WIDTH)
         32'sd4:  f = p[3] ^ p[2];
         32'sd5:  f = p[4] ^ p[2];
         32'sd6:  f = p[5] ^ p[4];
         32'sd7:  f = p[6] ^ p[5];
         32'sd8:  f = p[7] ^ p[5] ^ p[4] ^ p[3];
         default: f = p[7] ^ p[5] ^ p[4] ^ p[3];
      endcase
      return {r[WIDTH-2:0], f};
   endfunction

   state_t                     state_r;
   logic [NCH-1:0][WIDTH-1:0]  lfsr_r;
   logic [NCH*WIDTH-1:0]       x_r;
   logic [LEN_W-1:0]           len_r;
   logic                       bip_r;
   logic [NCH-1:0]             sn_bits_r;
   logic                       valid_r;
   logic                       done_r;
   logic [LEN_W-1:0]           cnt_r;

   logic [NCH-1:0][WIDTH-1:0]  x_u_s;
   logic [NCH-1:0][WIDTH-1:0]  lfsr_next_s;
   logic [NCH-1:0]             cmp_s;
   logic                       last_bit_s;

   // Per-channel offset-binary operand, comparator and next LFSR state.
   always_comb begin
      x_u_s       = '0;
      lfsr_next_s = '0;
      cmp_s       = '0;
      for (int c = 0; c < NCH; c++) begin
         // Inverting the MSB maps two's complement onto the unsigned compare range.
         x_u_s[c]       = x_r[c*WIDTH +: WIDTH] ^ {bip_r, {(WIDTH-1){1'b0}}};
         cmp_s[c]       = (lfsr_r[c] <= x_u_s[c]);
         lfsr_next_s[c] = lfsr_step(lfsr_r[c]);
      end
      last_bit_s = (cnt_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
   end

   // Run control FSM with registered stream, valid, done and count outputs.
   always_ff @(posedge i_clk_msng) begin
      if (i_rst_msng) begin
         state_r   <= ST_IDLE;
         x_r       <= '0;
         len_r     <= '0;
         bip_r     <= 1'b0;
         sn_bits_r <= '0;
         valid_r   <= 1'b0;
         done_r    <= 1'b0;
         cnt_r     <= '0;
         for (int c = 0; c < NCH; c++) begin
            lfsr_r[c] <= seed_of(c);
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               valid_r <= 1'b0;
               done_r  <= 1'b0;
               // A zero length would never reach its last bit, so such a start is dropped.
               if (bus.i_start_msng && !bus.i_stop_msng &&
                   (bus.i_len_msng != {LEN_W{1'b0}})) begin
                  x_r     <= bus.i_x_bn;
                  len_r   <= bus.i_len_msng;
                  bip_r   <= bus.i_bipolar_msng;
                  cnt_r   <= '0;
                  state_r <= ST_RUN;
                  for (int c = 0; c < NCH; c++) begin
                     lfsr_r[c] <= seed_of(c);
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               done_r <= 1'b0;
               if (bus.i_stop_msng) begin
                  state_r   <= ST_IDLE;
                  valid_r   <= 1'b0;
                  sn_bits_r <= '0;
               end else if (bus.i_hold_msng) begin
                  valid_r <= 1'b0;
               end else begin
                  sn_bits_r <= cmp_s;
                  valid_r   <= 1'b1;
                  lfsr_r    <= lfsr_next_s;
                  cnt_r     <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                  if (last_bit_s) begin
                     state_r <= ST_FLUSH;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_FLUSH: begin
               valid_r <= 1'b0;
               state_r <= ST_IDLE;
               // An abort here suppresses the completion pulse.
               if (bus.i_stop_msng) begin
                  sn_bits_r <= '0;
                  done_r    <= 1'b0;
               end else begin
                  done_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               valid_r   <= 1'b0;
               done_r    <= 1'b0;
               sn_bits_r <= '0;
            end
         endcase
      end
   end

   assign bus.o_sn_bits    = sn_bits_r;
   assign bus.o_valid_msng = valid_r;
   assign bus.o_done_msng  = done_r;
   assign bus.o_cnt_msng   = cnt_r;
   assign bus.o_busy_msng  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sng_array.sv
module tb_sng_array;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sng_array_if #(.WIDTH(4), .NCH(4), .LEN_W(10)) b4 ();
   sng_array_if #(.WIDTH(8), .NCH(4), .LEN_W(10)) b8 ();

   sng_array #(.WIDTH(4), .NCH(4), .LEN_W(10), .SEED_STEP(3)) dut4 (
      .i_clk_msng(clk), .i_rst_msng(rst), .bus(b4.slave));
   sng_array #(.WIDTH(8), .NCH(4), .LEN_W(10), .SEED_STEP(3)) dut8 (
      .i_clk_msng(clk), .i_rst_msng(rst), .bus(b8.slave));

   typedef logic [3:0][15:0] ones_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  exp_q4 [$];
   ones_t       exp_q8 [$];
   int          ones8 [4];
   logic [3:0]  seq_tab [15];
   logic [3:0]  mon_e4;
   ones_t       mon_e8;
   int          cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: per-bit compare on the 4-bit DUT, per-run density on the 8-bit DUT.
   always @(negedge clk) begin
      if (b4.o_valid_msng === 1'b1) begin
         if (exp_q4.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut4 extra bit: got %b, want none", b4.o_sn_bits);
         end else begin
            mon_e4 = exp_q4.pop_front();
            check("dut4 sn_bits", 32'(b4.o_sn_bits), 32'(mon_e4));
         end
      end
      if (b8.o_valid_msng === 1'b1) begin
         for (int c = 0; c < 4; c++) ones8[c] += int'(b8.o_sn_bits[c]);
      end
      if (b8.o_done_msng === 1'b1) begin
         if (exp_q8.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut8 extra done: got 1, want 0");
         end else begin
            mon_e8 = exp_q8.pop_front();
            for (int c = 0; c < 4; c++) begin
               check($sformatf("dut8 ones ch%0d", c), 32'(ones8[c]), 32'(mon_e8[c]));
            end
         end
         for (int c = 0; c < 4; c++) ones8[c] = 0;
      end
   end

   task automatic push4(input int first, input int n);
      for (int k = first; k < first + n; k++) exp_q4.push_back(seq_tab[k % 15]);
   endtask

   // Called just after a negedge; returns just after the next negedge (start sampled in between).
   task automatic start_dut(input logic sel8, input logic [31:0] x, input int len, input logic bip);
      if (sel8) begin
         b8.i_x_bn = x; b8.i_len_msng = len[9:0]; b8.i_bipolar_msng = bip; b8.i_start_msng = 1'b1;
      end else begin
         b4.i_x_bn = x[15:0]; b4.i_len_msng = len[9:0]; b4.i_bipolar_msng = bip; b4.i_start_msng = 1'b1;
      end
      @(negedge clk);
      b4.i_start_msng = 1'b0;
      b8.i_start_msng = 1'b0;
   endtask

   // Counts negedges since the start was driven until done shows, bounded by max.
   task automatic wait_done(input logic sel8, input int cyc0, input int max, output int c_out);
      c_out = cyc0;
      while (((sel8 ? b8.o_done_msng : b4.o_done_msng) !== 1'b1) && (c_out < max)) begin
         @(negedge clk);
         c_out++;
      end
   endtask

   initial begin
      // Channel c bit k for WIDTH=4, x=6, seeds 1,4,7,10 (bit c = channel c).
      seq_tab = '{4'b0011, 4'b1001, 4'b0011, 4'b0010, 4'b0001, 4'b0101, 4'b0110, 4'b0100,
                  4'b1001, 4'b1100, 4'b1100, 4'b0000, 4'b1000, 4'b1110, 4'b0010};
      for (int c = 0; c < 4; c++) ones8[c] = 0;
      b4.i_x_bn = '0; b4.i_len_msng = '0; b4.i_bipolar_msng = 1'b0;
      b4.i_start_msng = 1'b0; b4.i_stop_msng = 1'b0; b4.i_hold_msng = 1'b0;
      b8.i_x_bn = '0; b8.i_len_msng = '0; b8.i_bipolar_msng = 1'b0;
      b8.i_start_msng = 1'b0; b8.i_stop_msng = 1'b0; b8.i_hold_msng = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset sn_bits", 32'(b4.o_sn_bits), 32'd0);
      check("reset valid", 32'(b4.o_valid_msng), 32'd0);
      check("reset done", 32'(b4.o_done_msng), 32'd0);
      check("reset cnt", 32'(b4.o_cnt_msng), 32'd0);
      check("reset busy", 32'(b4.o_busy_msng), 32'd0);
      check("reset busy8", 32'(b8.o_busy_msng), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Seed sequence, len=15.
      push4(0, 15);
      start_dut(1'b0, 32'h6666, 15, 1'b0);
      check("seed busy after start", 32'(b4.o_busy_msng), 32'd1);
      check("seed valid latency", 32'(b4.o_valid_msng), 32'd0);
      wait_done(1'b0, 1, 40, cyc);
      check("seed done cycle", 32'(cyc), 32'd17);
      check("seed cnt", 32'(b4.o_cnt_msng), 32'd15);
      check("seed busy at done", 32'(b4.o_busy_msng), 32'd0);
      @(negedge clk);
      check("seed done width", 32'(b4.o_done_msng), 32'd0);

      // Hold for 3 cycles after the 4th bit, len=10.
      push4(0, 10);
      start_dut(1'b0, 32'h6666, 10, 1'b0);
      repeat (4) @(negedge clk);
      b4.i_hold_msng = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold valid low", 32'(b4.o_valid_msng), 32'd0);
      end
      b4.i_hold_msng = 1'b0;
      wait_done(1'b0, 8, 60, cyc);
      check("hold done cycle", 32'(cyc), 32'd15);
      check("hold cnt", 32'(b4.o_cnt_msng), 32'd10);
      @(negedge clk);

      // len=1.
      push4(0, 1);
      start_dut(1'b0, 32'h6666, 1, 1'b0);
      wait_done(1'b0, 1, 20, cyc);
      check("len1 done cycle", 32'(cyc), 32'd3);
      check("len1 cnt", 32'(b4.o_cnt_msng), 32'd1);
      @(negedge clk);

      // len=0 start is ignored.
      start_dut(1'b0, 32'h6666, 0, 1'b0);
      check("len0 busy", 32'(b4.o_busy_msng), 32'd0);
      @(negedge clk);
      check("len0 busy later", 32'(b4.o_busy_msng), 32'd0);
      check("len0 cnt kept", 32'(b4.o_cnt_msng), 32'd1);

      // Start and stop together while idle.
      b4.i_stop_msng = 1'b1;
      start_dut(1'b0, 32'h6666, 5, 1'b0);
      b4.i_stop_msng = 1'b0;
      check("start+stop busy", 32'(b4.o_busy_msng), 32'd0);
      @(negedge clk);

      // Start during RUN (n3) and FLUSH (n6) are ignored, len=5.
      push4(0, 5);
      start_dut(1'b0, 32'h6666, 5, 1'b0);
      @(negedge clk);
      @(negedge clk);
      b4.i_start_msng = 1'b1; b4.i_x_bn = 16'hFFFF; b4.i_len_msng = 10'd3;
      @(negedge clk);
      b4.i_start_msng = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("flush busy", 32'(b4.o_busy_msng), 32'd1);
      b4.i_start_msng = 1'b1;
      @(negedge clk);
      b4.i_start_msng = 1'b0;
      check("restart done", 32'(b4.o_done_msng), 32'd1);
      check("restart busy at done", 32'(b4.o_busy_msng), 32'd0);
      @(negedge clk);
      check("flush start ignored", 32'(b4.o_busy_msng), 32'd0);

      // Stop after 40 bits of a len=100 run.
      push4(0, 40);
      start_dut(1'b0, 32'h6666, 100, 1'b0);
      repeat (40) @(negedge clk);
      b4.i_stop_msng = 1'b1;
      @(negedge clk);
      b4.i_stop_msng = 1'b0;
      check("stop busy", 32'(b4.o_busy_msng), 32'd0);
      check("stop valid", 32'(b4.o_valid_msng), 32'd0);
      check("stop sn_bits", 32'(b4.o_sn_bits), 32'd0);
      check("stop cnt", 32'(b4.o_cnt_msng), 32'd40);
      check("stop done", 32'(b4.o_done_msng), 32'd0);
      @(negedge clk);
      check("stop no done", 32'(b4.o_done_msng), 32'd0);
      check("stop queue drained", 32'(exp_q4.size()), 32'd0);

      // Reset mid-run, then the seed sequence repeats.
      push4(0, 6);
      start_dut(1'b0, 32'h6666, 15, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst sn_bits", 32'(b4.o_sn_bits), 32'd0);
      check("midrst valid", 32'(b4.o_valid_msng), 32'd0);
      check("midrst done", 32'(b4.o_done_msng), 32'd0);
      check("midrst cnt", 32'(b4.o_cnt_msng), 32'd0);
      check("midrst busy", 32'(b4.o_busy_msng), 32'd0);
      push4(0, 15);
      start_dut(1'b0, 32'h6666, 15, 1'b0);
      wait_done(1'b0, 1, 40, cyc);
      check("rerun done cycle", 32'(cyc), 32'd17);
      check("rerun cnt", 32'(b4.o_cnt_msng), 32'd15);
      @(negedge clk);

      // Density, WIDTH=8, unipolar: channels x = 0, 1, 128, 255.
      exp_q8.push_back({16'd255, 16'd128, 16'd1, 16'd0});
      start_dut(1'b1, {8'hFF, 8'h80, 8'h01, 8'h00}, 255, 1'b0);
      wait_done(1'b1, 1, 400, cyc);
      check("uni done cycle", 32'(cyc), 32'd257);
      check("uni cnt", 32'(b8.o_cnt_msng), 32'd255);
      @(negedge clk);

      // Density, bipolar: channels x = -128, 0, 127, -1.
      exp_q8.push_back({16'd127, 16'd255, 16'd128, 16'd0});
      start_dut(1'b1, {8'hFF, 8'h7F, 8'h00, 8'h80}, 255, 1'b1);
      wait_done(1'b1, 1, 400, cyc);
      check("bip done cycle", 32'(cyc), 32'd257);
      @(negedge clk);

      check("final q4 empty", 32'(exp_q4.size()), 32'd0);
      check("final q8 empty", 32'(exp_q8.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
